mem_arbiter: RTL and testbench

- Shares the single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU) in the multi-cycle RV32 core.
- Arbitrates, latches the winning request, drives the downstream valid/ready request channel, waits for a variable-latency response, then returns the response to the winner.
- Handles one outstanding transaction at a time.

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle for mem_arbiter: IFU and LSU request channels,
// the downstream memory channel and the busy flag.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      ifu_req_valid;
    logic                      ifu_req_ready;
    logic [ADDR_WIDTH-1:0]     ifu_addr;
    logic                      ifu_resp_valid;
    logic [DATA_WIDTH-1:0]     ifu_rdata;

    logic                      lsu_req_valid;
    logic                      lsu_req_ready;
    logic [ADDR_WIDTH-1:0]     lsu_addr;
    logic                      lsu_wen;
    logic [DATA_WIDTH-1:0]     lsu_wdata;
    logic [DATA_WIDTH/8-1:0]   lsu_wmask;
    logic                      lsu_resp_valid;
    logic [DATA_WIDTH-1:0]     lsu_rdata;

    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic                      mem_wen;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wmask;
    logic                      mem_resp_valid;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    logic                      busy;

    // Arbiter side
    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output busy
    );

    // Requester/memory side
    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// IFU/LSU shared memory-port arbiter, one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN for alternating grant on contention (default: LSU priority).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int MASK_W = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wen;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [MASK_W-1:0]     r_wmask;
    logic                  r_grant;      // 1 = LSU owns the transaction
    logic [DATA_WIDTH-1:0] r_ifu_rdata;
    logic [DATA_WIDTH-1:0] r_lsu_rdata;

    logic w_idle;
    logic w_lsu_first;
    logic w_lsu_win;
    logic w_ifu_win;
    logic w_accept;

    assign w_idle = (r_state == S_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;                  // 1 = LSU was granted last

    assign w_lsu_first = ~r_last_grant;

    always_ff @(posedge clk) begin
        if (rst)
            r_last_grant <= 1'b0;
        else if (w_accept)
            r_last_grant <= w_lsu_win;
    end
`else
    assign w_lsu_first = 1'b1;
`endif

    // Priority only matters when both request; a lone requester always wins.
    assign w_lsu_win = w_idle & bus.lsu_req_valid & (~bus.ifu_req_valid | w_lsu_first);
    assign w_ifu_win = w_idle & bus.ifu_req_valid & ~w_lsu_win;
    assign w_accept  = w_lsu_win | w_ifu_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_grant     <= 1'b0;
            r_ifu_rdata <= '0;
            r_lsu_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_lsu_win) begin
                        r_addr  <= bus.lsu_addr;
                        r_wen   <= bus.lsu_wen;
                        r_wdata <= bus.lsu_wdata;
                        r_wmask <= bus.lsu_wmask;
                        r_grant <= 1'b1;
                        r_state <= S_ISSUE;
                    end else if (w_ifu_win) begin
                        r_addr  <= bus.ifu_addr;
                        r_wen   <= 1'b0;
                        r_wdata <= '0;
                        r_wmask <= '0;
                        r_grant <= 1'b0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_req_ready)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        if (r_grant)
                            r_lsu_rdata <= r_wen ? '0 : bus.mem_rdata;
                        else
                            r_ifu_rdata <= bus.mem_rdata;
                        r_state <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ifu_req_ready  = w_ifu_win;
    assign bus.lsu_req_ready  = w_lsu_win;
    assign bus.ifu_resp_valid = (r_state == S_RESP) & ~r_grant;
    assign bus.lsu_resp_valid = (r_state == S_RESP) &  r_grant;
    assign bus.ifu_rdata      = r_ifu_rdata;
    assign bus.lsu_rdata      = r_lsu_rdata;
    assign bus.mem_req_valid  = (r_state == S_ISSUE);
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wen        = r_wen;
    assign bus.mem_wdata      = r_wdata;
    assign bus.mem_wmask      = r_wmask;
    assign bus.busy           = ~w_idle;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter; honours ARB_ROUND_ROBIN_EN when
// checking the grant order under sustained contention.
module tb_mem_arbiter;
    localparam logic [31:0] A = 32'h8000_0000;
    localparam logic [31:0] B = 32'h8000_1000;
    localparam logic [31:0] C = 32'h8000_0100;
    localparam logic [31:0] E = 32'h8000_2000;
    localparam logic [31:0] W = 32'hDEAD_BEEF;
    localparam logic [31:0] D = 32'h0000_0413;
    localparam logic [31:0] K = 32'hCAFE_F00D;
    localparam logic [31:0] P = 32'h1111_1111;
    localparam logic [31:0] Q = 32'h2222_2222;
    localparam logic [31:0] R = 32'h4444_4444;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;  logic [31:0] ia;
        logic        lv;  logic [31:0] la; logic lw; logic [31:0] ld; logic [3:0] lm;
        logic        mrdy; logic mrv; logic [31:0] mrd;
        logic [138:0] exp;
    } vec_t;

    vec_t vq[$];
    int   nvec  = 0;
    int   nfail = 0;

    function automatic void add(
        input string name, input logic r,
        input logic iv, input logic [31:0] ia,
        input logic lv, input logic [31:0] la, input logic lw,
        input logic [31:0] ld, input logic [3:0] lm,
        input logic mrdy, input logic mrv, input logic [31:0] mrd,
        input logic e_ir, input logic e_lr, input logic e_mv,
        input logic [31:0] e_ma, input logic e_mw, input logic [31:0] e_md,
        input logic [3:0] e_mm, input logic e_irv, input logic [31:0] e_ird,
        input logic e_lrv, input logic [31:0] e_lrd, input logic e_busy);
        vec_t v;
        v.name = name; v.rst = r;
        v.iv = iv; v.ia = ia; v.lv = lv; v.la = la; v.lw = lw; v.ld = ld; v.lm = lm;
        v.mrdy = mrdy; v.mrv = mrv; v.mrd = mrd;
        v.exp = {e_ir, e_lr, e_mv, e_ma, e_mw, e_md, e_mm,
                 e_irv, e_ird, e_lrv, e_lrd, e_busy};
        vq.push_back(v);
    endfunction

    function automatic logic [138:0] observed();
        return {bus.ifu_req_ready, bus.lsu_req_ready, bus.mem_req_valid,
                bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask,
                bus.ifu_resp_valid, bus.ifu_rdata, bus.lsu_resp_valid,
                bus.lsu_rdata, bus.busy};
    endfunction

    task automatic drive(input logic r, input logic iv, input logic [31:0] ia,
                         input logic lv, input logic [31:0] la, input logic lw,
                         input logic [31:0] ld, input logic [3:0] lm,
                         input logic mrdy, input logic mrv, input logic [31:0] mrd);
        rst = r;
        bus.ifu_req_valid = iv; bus.ifu_addr = ia;
        bus.lsu_req_valid = lv; bus.lsu_addr = la; bus.lsu_wen = lw;
        bus.lsu_wdata = ld; bus.lsu_wmask = lm;
        bus.mem_req_ready = mrdy; bus.mem_resp_valid = mrv; bus.mem_rdata = mrd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both requesters held valid across four transactions; records grant order.
    task automatic contention_seq();
        logic exp_lsu [4];
        logic found;
        logic got_lsu;
`ifdef ARB_ROUND_ROBIN_EN
        exp_lsu = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_lsu = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int t = 0; t < 4; t++) begin
            drive(1'b0, 1'b1, C, 1'b1, E, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h100 + t);
            found = 1'b0;
            got_lsu = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                if (bus.ifu_req_ready || bus.lsu_req_ready) begin
                    found = 1'b1;
                    got_lsu = bus.lsu_req_ready;
                end
                step();
            end
            nvec++;
            if (!found) begin
                nfail++;
                $display("FAIL contention_grant%0d: no accept within 8 cycles, required grant lsu=%0b", t, exp_lsu[t]);
            end else if (got_lsu !== exp_lsu[t]) begin
                nfail++;
                $display("FAIL contention_grant%0d: got lsu=%0b required lsu=%0b", t, got_lsu, exp_lsu[t]);
            end
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
                    found = 1'b1;
                    got_lsu = bus.lsu_resp_valid;
                end
                step();
            end
            nvec++;
            if (!found || got_lsu !== exp_lsu[t]) begin
                nfail++;
                $display("FAIL contention_resp%0d: seen=%0b lsu=%0b required lsu=%0b", t, found, got_lsu, exp_lsu[t]);
            end
        end
    endtask

    initial begin
        //   name             rst iv ia lv la lw ld lm    rdy rv rdata        | ir lr mv ma mw md mm    irv ird lrv lrd busy
        add("rst_state",      1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        add("ifu_accept",     0, 1, A, 0, 0, 0, 0, 4'h0, 0, 0, 0,             1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        add("ifu_issue",      0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0,             0, 0, 1, A, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        add("ifu_wait",       0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, D,             0, 0, 0, A, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        add("ifu_resp",       0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, A, 0, 0, 4'h0, 1, D, 0, 0, 1);
        add("ifu_idle",       0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, A, 0, 0, 4'h0, 0, D, 0, 0, 0);
        add("lsu_wr_accept",  0, 0, 0, 1, B, 1, W, 4'hF, 0, 0, 0,             0, 1, 0, A, 0, 0, 4'h0, 0, D, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add("lsu_wr_stall", 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,           0, 0, 1, B, 1, W, 4'hF, 0, D, 0, 0, 1);
        add("lsu_wr_issue",   0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0,             0, 0, 1, B, 1, W, 4'hF, 0, D, 0, 0, 1);
        add("lsu_wr_wait",    0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 32'h12345678,  0, 0, 0, B, 1, W, 4'hF, 0, D, 0, 0, 1);
        add("lsu_wr_resp",    0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, B, 1, W, 4'hF, 0, D, 1, 0, 1);
        add("lsu_wr_idle",    0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, B, 1, W, 4'hF, 0, D, 0, 0, 0);
        add("rst_idle",       1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, B, 1, W, 4'hF, 0, D, 0, 0, 0);
        add("both_valid",     0, 1, C, 1, E, 0, 0, 4'h0, 0, 0, 0,             0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        add("lsu_rd_issue",   0, 1, C, 0, 0, 0, 0, 4'h0, 1, 0, 0,             0, 0, 1, E, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        add("lsu_rd_wait",    0, 1, C, 0, 0, 0, 0, 4'h0, 0, 1, K,             0, 0, 0, E, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        add("lsu_rd_resp",    0, 1, C, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, E, 0, 0, 4'h0, 0, 0, 1, K, 1);
        add("ifu_after_lsu",  0, 1, C, 0, 0, 0, 0, 4'h0, 0, 0, 0,             1, 0, 0, E, 0, 0, 4'h0, 0, 0, 0, K, 0);
        add("ifu2_issue",     0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0,             0, 0, 1, C, 0, 0, 4'h0, 0, 0, 0, K, 1);
        add("ifu2_wait",      0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, P,             0, 0, 0, C, 0, 0, 4'h0, 0, 0, 0, K, 1);
        add("ifu2_resp",      0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, C, 0, 0, 4'h0, 1, P, 0, K, 1);
        add("spur_idle",      0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 32'hBAD,       0, 0, 0, C, 0, 0, 4'h0, 0, P, 0, K, 0);
        add("spur_accept",    0, 1, A, 0, 0, 0, 0, 4'h0, 0, 1, 32'hBAD,       1, 0, 0, C, 0, 0, 4'h0, 0, P, 0, K, 0);
        add("spur_issue",     0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 32'hBAD,       0, 0, 1, A, 0, 0, 4'h0, 0, P, 0, K, 1);
        add("spur_issue2",    0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0,             0, 0, 1, A, 0, 0, 4'h0, 0, P, 0, K, 1);
        add("spur_wait",      0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, A, 0, 0, 4'h0, 0, P, 0, K, 1);
        add("spur_wait_rv",   0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, Q,             0, 0, 0, A, 0, 0, 4'h0, 0, P, 0, K, 1);
        add("spur_resp",      0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, A, 0, 0, 4'h0, 1, Q, 0, K, 1);
        add("lsu_rd2_accept", 0, 0, 0, 1, B, 0, 0, 4'h0, 0, 0, 0,             0, 1, 0, A, 0, 0, 4'h0, 0, Q, 0, K, 0);
        add("lsu_rd2_issue",  0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0,             0, 0, 1, B, 0, 0, 4'h0, 0, Q, 0, K, 1);
        add("rst_in_wait",    1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, B, 0, 0, 4'h0, 0, Q, 0, K, 1);
        add("post_rst_rv",    0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 32'h33333333,  0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        add("post_rst_idle",  0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        add("ifu3_accept",    0, 1, A, 0, 0, 0, 0, 4'h0, 0, 0, 0,             1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0);
        add("ifu3_issue",     0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0,             0, 0, 1, A, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        add("ifu3_wait",      0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 1, R,             0, 0, 0, A, 0, 0, 4'h0, 0, 0, 0, 0, 1);
        add("ifu3_resp",      0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, A, 0, 0, 4'h0, 1, R, 0, 0, 1);
        add("ifu3_idle",      0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0,             0, 0, 0, A, 0, 0, 4'h0, 0, R, 0, 0, 0);

        drive(1'b1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        step();
        step();

        foreach (vq[i]) begin
            logic [138:0] got;
            drive(vq[i].rst, vq[i].iv, vq[i].ia, vq[i].lv, vq[i].la, vq[i].lw,
                  vq[i].ld, vq[i].lm, vq[i].mrdy, vq[i].mrv, vq[i].mrd);
            @(negedge clk);
            got = observed();
            nvec++;
            if (got !== vq[i].exp) begin
                nfail++;
                $display("FAIL %s: got %h required %h", vq[i].name, got, vq[i].exp);
            end
            step();
        end

        contention_seq();

        drive(1'b0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
